// File: rtl/ascii_num_pkg.sv
// ascii_num_pkg
// Shared types and constants for the streaming ASCII number parser:
//   base_t     - 2-bit token base (matches the out_base encoding)
//   state_t    - parser FSM states
//   CH_*       - terminator / separator characters
//   base_radix - numeric radix (10/16/8/2) for a base_t
package ascii_num_pkg;

    typedef enum logic [1:0] {
        BASE_DEC = 2'd0,
        BASE_HEX = 2'd1,
        BASE_OCT = 2'd2,
        BASE_BIN = 2'd3
    } base_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ZERO   = 3'd1,
        PREFIX = 3'd2,
        DIGITS = 3'd3,
        ERROR  = 3'd4,
        HOLD   = 3'd5
    } state_t;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_US = 8'h5F;

    function automatic logic [4:0] base_radix(input base_t b);
        case (b)
            BASE_HEX: return 5'd16;
            BASE_OCT: return 5'd8;
            BASE_BIN: return 5'd2;
            default:  return 5'd10;
        endcase
    endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// ascii_digit_decode
// Combinational character classifier.
//   in_char  - ASCII character
//   base     - base currently in force
//   digit    - numeric value of the character (0-15) when it is a digit
//   digit_ok - character is a digit that is legal in the given base
//   is_term  - character is a token terminator (LF, CR, space)
module ascii_digit_decode
    import ascii_num_pkg::*;
(
    input  logic [7:0] in_char,
    input  base_t      base,
    output logic [3:0] digit,
    output logic       digit_ok,
    output logic       is_term
);

    logic [4:0] value;
    logic       is_digit_char;

    always_comb begin
        value         = 5'd0;
        is_digit_char = 1'b0;
        if (in_char >= 8'h30 && in_char <= 8'h39) begin
            value         = {1'b0, in_char[3:0]};
            is_digit_char = 1'b1;
        end else if ((in_char >= 8'h61 && in_char <= 8'h66) ||
                     (in_char >= 8'h41 && in_char <= 8'h46)) begin
            // 'a'/'A' have low bits 3'b001, so value = 9 + low bits
            value         = 5'd9 + {2'b00, in_char[2:0]};
            is_digit_char = 1'b1;
        end
    end

    assign digit    = value[3:0];
    assign digit_ok = is_digit_char && (value < base_radix(base));
    assign is_term  = (in_char == CH_LF) || (in_char == CH_CR) || (in_char == CH_SP);

endmodule

// File: rtl/ascii_num_parser.sv
// ascii_num_parser
// Streaming parser for decimal, 0x hex, 0o octal and 0b binary literals,
// one character per cycle, one registered result per terminated token.
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - character handshake, in_char the character
//   out_valid/out_ready - result handshake
//   out_value         - value modulo 2^WIDTH (0 on error)
//   out_base          - 0 dec, 1 hex, 2 oct, 3 bin
//   out_error         - malformed token
//   out_overflow      - value exceeded WIDTH bits (0 when out_error)
module ascii_num_parser
    import ascii_num_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [1:0]       out_base,
    output logic             out_error,
    output logic             out_overflow
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;
    base_t            base_reg, base_next;
    logic [WIDTH-1:0] out_value_reg, out_value_next;
    base_t            out_base_reg, out_base_next;
    logic             out_error_reg, out_error_next;
    logic             out_overflow_reg, out_overflow_next;

    logic [3:0]       digit;
    logic             digit_ok;
    logic             is_term;
    logic [7:0]       char_lc;
    logic             accept;

    // Multiply-add carried at WIDTH+4 bits so the top nibble catches overflow.
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] scaled;
    logic [WIDTH+3:0] mac;
    logic             mac_ovf;

    ascii_digit_decode u_decode (
        .in_char  (in_char),
        .base     (base_reg),
        .digit    (digit),
        .digit_ok (digit_ok),
        .is_term  (is_term)
    );

    assign char_lc = in_char | 8'h20;   // fold upper-case prefix letters
    assign accept  = in_valid && (state_reg != HOLD);

    // Every radix is a shift or shift-sum, so no general multiplier is needed.
    assign acc_ext = {4'b0000, acc_reg};
    always_comb begin
        case (base_reg)
            BASE_HEX: scaled = acc_ext << 4;
            BASE_OCT: scaled = acc_ext << 3;
            BASE_BIN: scaled = acc_ext << 1;
            default:  scaled = (acc_ext << 3) + (acc_ext << 1);
        endcase
    end
    assign mac     = scaled + {{WIDTH{1'b0}}, digit};
    assign mac_ovf = |mac[WIDTH+3:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            ovf_reg          <= 1'b0;
            base_reg         <= BASE_DEC;
            out_value_reg    <= '0;
            out_base_reg     <= BASE_DEC;
            out_error_reg    <= 1'b0;
            out_overflow_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            ovf_reg          <= ovf_next;
            base_reg         <= base_next;
            out_value_reg    <= out_value_next;
            out_base_reg     <= out_base_next;
            out_error_reg    <= out_error_next;
            out_overflow_reg <= out_overflow_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        acc_next          = acc_reg;
        ovf_next          = ovf_reg;
        base_next         = base_reg;
        out_value_next    = out_value_reg;
        out_base_next     = out_base_reg;
        out_error_next    = out_error_reg;
        out_overflow_next = out_overflow_reg;

        case (state_reg)
            IDLE: begin
                if (accept && !is_term) begin
                    if (in_char == 8'h30) begin
                        state_next = ZERO;
                    end else if (digit_ok) begin
                        // accumulator is zero here, so mac == digit
                        acc_next   = mac[WIDTH-1:0];
                        state_next = DIGITS;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            ZERO: begin
                if (accept) begin
                    if (char_lc == 8'h78) begin
                        base_next  = BASE_HEX;
                        state_next = PREFIX;
                    end else if (char_lc == 8'h6F) begin
                        base_next  = BASE_OCT;
                        state_next = PREFIX;
                    end else if (char_lc == 8'h62) begin
                        base_next  = BASE_BIN;
                        state_next = PREFIX;
                    end else if (digit_ok) begin
                        acc_next   = mac[WIDTH-1:0];
                        state_next = DIGITS;
                    end else if (is_term) begin
                        out_value_next    = '0;
                        out_base_next     = BASE_DEC;
                        out_error_next    = 1'b0;
                        out_overflow_next = 1'b0;
                        state_next        = HOLD;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            PREFIX: begin
                if (accept) begin
                    if (digit_ok) begin
                        acc_next   = mac[WIDTH-1:0];
                        ovf_next   = ovf_reg | mac_ovf;
                        state_next = DIGITS;
                    end else if (is_term) begin
                        // prefix with no digits is malformed
                        out_value_next    = '0;
                        out_base_next     = base_reg;
                        out_error_next    = 1'b1;
                        out_overflow_next = 1'b0;
                        state_next        = HOLD;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            DIGITS: begin
                if (accept) begin
                    if (digit_ok) begin
                        acc_next = mac[WIDTH-1:0];
                        ovf_next = ovf_reg | mac_ovf;
                    end else if (in_char == CH_US) begin
                        state_next = DIGITS;
                    end else if (is_term) begin
                        out_value_next    = acc_reg;
                        out_base_next     = base_reg;
                        out_error_next    = 1'b0;
                        out_overflow_next = ovf_reg;
                        state_next        = HOLD;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                if (accept && is_term) begin
                    out_value_next    = '0;
                    out_base_next     = base_reg;
                    out_error_next    = 1'b1;
                    out_overflow_next = 1'b0;
                    state_next        = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    base_next  = BASE_DEC;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both handshake signals come straight from the state register.
    assign out_valid    = (state_reg == HOLD);
    assign in_ready     = (state_reg != HOLD);
    assign out_value    = out_value_reg;
    assign out_base     = out_base_reg;
    assign out_error    = out_error_reg;
    assign out_overflow = out_overflow_reg;

endmodule
